// File: rtl/delay_buffer_pkg.sv
// Shared constants for the delay buffer: parameter limits, counter widths
// and the mode encodings used on the mode input.
package delay_buffer_pkg;

    localparam int MAX_WIDTH  = 32;
    localparam int MAX_DEPTH  = 16;
    localparam int MAX_PERIOD = 16;

    // Counter widths are sized to hold the maximum value itself, so a counter
    // width never depends on the chosen parameters.
    localparam int PCNT_W = $clog2(MAX_PERIOD + 1);
    localparam int FCNT_W = $clog2(MAX_DEPTH + 1);

    typedef enum logic {
        MODE_DECIM = 1'b0,
        MODE_CONT  = 1'b1
    } mode_e;

endpackage

// File: rtl/delay_buffer_if.sv
// Data/control bundle of the delay buffer.
//   master : drives enable, flush, mode, data_in; observes data_out, strobe, fill_valid
//   slave  : the delay buffer itself
interface delay_buffer_if #(
    parameter int WIDTH = 1
);
    logic             enable;
    logic             flush;
    logic             mode;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             strobe;
    logic             fill_valid;

    modport master (
        output enable, flush, mode, data_in,
        input  data_out, strobe, fill_valid
    );

    modport slave (
        input  enable, flush, mode, data_in,
        output data_out, strobe, fill_valid
    );
endinterface

// File: rtl/delay_buffer_tick_gen.sv
// Update-tick generator for the delay buffer.
//   clk, reset_L : clock and asynchronous active-low reset
//   enable       : advance the period counter this cycle
//   flush        : synchronous clear of the period counter
//   mode         : 0 = tick every PERIOD enabled edges, 1 = tick every enabled edge
//   tick         : combinational, high when the coming edge is an update edge
module tick_gen
    import delay_buffer_pkg::*;
#(
    parameter int PERIOD = 3
) (
    input  logic clk,
    input  logic reset_L,
    input  logic enable,
    input  logic flush,
    input  logic mode,
    output logic tick
);

    localparam logic [PCNT_W-1:0] LAST = PCNT_W'(PERIOD - 1);

    logic [PCNT_W-1:0] cnt, cnt_nxt;
    logic              mode_q;
    logic              mode_chg;
    logic              at_last;

    assign mode_chg = (mode != mode_q);
    assign at_last  = (cnt == LAST);

    // mode_q follows mode on every edge so a switch is seen exactly once.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            cnt    <= '0;
            mode_q <= MODE_DECIM;
        end else begin
            cnt    <= cnt_nxt;
            mode_q <= mode;
        end
    end

    always_comb begin
        cnt_nxt = cnt;
        if (flush || mode_chg) begin
            cnt_nxt = '0;
        end else if (enable) begin
            if (mode == MODE_CONT || at_last) cnt_nxt = '0;
            else                              cnt_nxt = cnt + 1'b1;
        end
    end

    // A mode-0 switch edge never ticks, except with PERIOD=1 where decimated
    // mode must be indistinguishable from continuous mode.
    always_comb begin
        tick = 1'b0;
        if (enable && !flush) begin
            if (mode == MODE_CONT)                          tick = 1'b1;
            else if (at_last && (!mode_chg || PERIOD == 1)) tick = 1'b1;
        end
    end

endmodule

// File: rtl/delay_buffer.sv
// DEPTH-stage delay line with optional decimated output.
//   clk, reset_L : clock and asynchronous active-low reset
//   bus.enable   : advance the chain and period counter
//   bus.flush    : clear chain, counters and fill status (data_out holds)
//   bus.mode     : 0 = output every PERIOD enabled cycles, 1 = every enabled cycle
//   bus.data_in  : sample entering stage 0
//   bus.data_out : registered oldest stage, loaded on update ticks once filled
//   bus.strobe   : one-cycle pulse after data_out was loaded
//   bus.fill_valid : DEPTH enabled shifts seen since reset/flush
module delay_buffer
    import delay_buffer_pkg::*;
#(
    parameter int WIDTH  = 1,
    parameter int DEPTH  = 2,
    parameter int PERIOD = 3
) (
    input  logic           clk,
    input  logic           reset_L,
    delay_buffer_if.slave  bus
);

    localparam logic [FCNT_W-1:0] FULL = FCNT_W'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] stage;
    logic [FCNT_W-1:0]           fill_cnt;
    logic [WIDTH-1:0]            dout_q;
    logic                        strobe_q;
    logic                        filled;
    logic                        tick;

    assign filled = (fill_cnt == FULL);

    tick_gen #(.PERIOD(PERIOD)) u_tick (
        .clk     (clk),
        .reset_L (reset_L),
        .enable  (bus.enable),
        .flush   (bus.flush),
        .mode    (bus.mode),
        .tick    (tick)
    );

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            stage    <= '0;
            fill_cnt <= '0;
        end else if (bus.flush) begin
            stage    <= '0;
            fill_cnt <= '0;
        end else if (bus.enable) begin
            for (int k = DEPTH - 1; k > 0; k--) stage[k] <= stage[k-1];
            stage[0] <= bus.data_in;
            if (!filled) fill_cnt <= fill_cnt + 1'b1;
        end
    end

    // tick is already gated by enable/flush, so it alone decides the load;
    // the oldest stage is sampled before this edge's shift.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            dout_q   <= '0;
            strobe_q <= 1'b0;
        end else begin
            strobe_q <= tick && filled;
            if (tick && filled) dout_q <= stage[DEPTH-1];
        end
    end

    assign bus.data_out   = dout_q;
    assign bus.strobe     = strobe_q;
    assign bus.fill_valid = filled;

endmodule

// File: tb/tb_delay_buffer.sv
module tb_delay_buffer;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 2;
    localparam int PERIOD = 3;

    logic clk = 1'b0;
    logic reset_L = 1'b0;
    logic run = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    delay_buffer_if #(.WIDTH(WIDTH)) bus ();

    delay_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PERIOD(PERIOD)) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a window of the last DEPTH samples, and a count of
    // enabled mode-0 edges since the last restart; every PERIOD-th one ticks.
    logic [WIDTH-1:0] hist[$];
    int               ecount;
    logic             m_prev;
    logic [WIDTH-1:0] e_dout;
    logic             e_strobe;
    logic             chg, tk;

    always @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            hist.delete();
            ecount   = 0;
            m_prev   = 1'b0;
            e_dout   = '0;
            e_strobe = 1'b0;
        end else begin
            chg    = (bus.mode != m_prev);
            m_prev = bus.mode;
            if (bus.flush) begin
                hist.delete();
                ecount   = 0;
                e_strobe = 1'b0;
            end else if (bus.enable) begin
                if (bus.mode) begin
                    ecount = 0;
                    tk = 1'b1;
                end else if (chg) begin
                    ecount = 0;
                    tk = (PERIOD == 1);
                end else begin
                    ecount++;
                    tk = (ecount % PERIOD == 0);
                end
                e_strobe = tk && (hist.size() == DEPTH);
                if (e_strobe) e_dout = hist[0];
                hist.push_back(bus.data_in);
                if (hist.size() > DEPTH) void'(hist.pop_front());
            end else begin
                e_strobe = 1'b0;
                if (chg) ecount = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (run) begin
            check("model data_out", 32'(bus.data_out), 32'(e_dout));
            check("model strobe", 32'(bus.strobe), 32'(e_strobe));
            check("model fill_valid", 32'(bus.fill_valid), 32'(hist.size() == DEPTH));
        end
    end

    task automatic step(input logic en, input logic fl, input logic md, input logic [WIDTH-1:0] d);
        @(negedge clk);
        bus.enable  = en;
        bus.flush   = fl;
        bus.mode    = md;
        bus.data_in = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.enable  = 1'b0;
        bus.flush   = 1'b0;
        bus.mode    = 1'b0;
        bus.data_in = '0;
        #12;
        check("reset data_out", 32'(bus.data_out), 0);
        check("reset strobe", 32'(bus.strobe), 0);
        check("reset fill_valid", 32'(bus.fill_valid), 0);
        @(negedge clk);
        reset_L = 1'b1;
        run = 1'b1;

        // decimated mode, samples 1..12
        for (int k = 1; k <= 12; k++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(k));
            if (k == 1) check("fill after 1 shift", 32'(bus.fill_valid), 0);
            if (k == 2) check("fill after 2 shifts", 32'(bus.fill_valid), 1);
            if (k == 3) begin
                check("first strobe", 32'(bus.strobe), 1);
                check("first data_out", 32'(bus.data_out), 1);
            end
            if (k == 4) check("strobe one-cycle", 32'(bus.strobe), 0);
            if (k == 6) check("second data_out", 32'(bus.data_out), 4);
        end

        // freeze for 4 cycles, then resume
        for (int k = 0; k < 4; k++) step(1'b0, 1'b0, 1'b0, 8'hEE);
        check("frozen data_out", 32'(bus.data_out), 10);
        for (int k = 13; k <= 15; k++) step(1'b1, 1'b0, 1'b0, WIDTH'(k));
        check("resume strobe", 32'(bus.strobe), 1);
        check("resume data_out", 32'(bus.data_out), 13);

        // flush overrides enable
        step(1'b1, 1'b1, 1'b0, 8'd99);
        check("flush fill_valid", 32'(bus.fill_valid), 0);
        check("flush holds data_out", 32'(bus.data_out), 13);
        for (int k = 16; k <= 18; k++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(k));
            if (k < 18) check("no strobe while refilling", 32'(bus.strobe), 0);
        end
        check("post-flush data_out", 32'(bus.data_out), 16);

        // continuous mode: latency of 3 edges
        for (int k = 20; k <= 27; k++) begin
            step(1'b1, 1'b0, 1'b1, WIDTH'(k));
            if (k >= 22) check("continuous data_out", 32'(bus.data_out), 32'(k - 2));
        end

        // back to decimated: tick on the 3rd enabled edge after the switch
        for (int k = 30; k <= 33; k++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(k));
            check("switch strobe timing", 32'(bus.strobe), 32'(k == 33));
        end
        check("switch data_out", 32'(bus.data_out), 31);
        for (int k = 34; k <= 36; k++) step(1'b1, 1'b0, 1'b0, WIDTH'(k));

        // asynchronous reset between edges
        @(posedge clk);
        #2 reset_L = 1'b0;
        #1;
        check("async rst data_out", 32'(bus.data_out), 0);
        check("async rst strobe", 32'(bus.strobe), 0);
        check("async rst fill_valid", 32'(bus.fill_valid), 0);
        @(posedge clk);
        #2 reset_L = 1'b1;
        for (int k = 40; k <= 46; k++) begin
            step(1'b1, 1'b0, 1'b0, WIDTH'(k));
            if (k == 42) check("after reset data_out", 32'(bus.data_out), 40);
        end

        @(negedge clk);
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
